// File: rtl/mult_pkg.sv
// Shared definitions for the M-extension multiplier: func3 encodings and the
// operand-signedness / product-half decode used by the pipeline front end.
package mult_pkg;

  localparam logic [2:0] MUL_F3    = 3'b000;
  localparam logic [2:0] MULH_F3   = 3'b001;
  localparam logic [2:0] MULHSU_F3 = 3'b010;
  localparam logic [2:0] MULHU_F3  = 3'b011;

  typedef struct packed {
    logic a_signed;
    logic b_signed;
    logic hi;
    logic illegal;
  } mode_t;

  function automatic mode_t decode_mode(input logic [2:0] f3);
    mode_t m;
    m = '0;
    case (f3)
      MUL_F3:    m.hi = 1'b0;
      MULH_F3:   begin m.a_signed = 1'b1; m.b_signed = 1'b1; m.hi = 1'b1; end
      MULHSU_F3: begin m.a_signed = 1'b1; m.hi = 1'b1; end
      MULHU_F3:  m.hi = 1'b1;
      default:   m.illegal = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pipe_stage_vld.sv
// One pipeline stage: data register plus valid bit, loaded on advance,
// valid squashed by flush, everything cleared by asynchronous reset.
module pipe_stage_vld #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         flush,
  input  logic         adv_i,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (adv_i) begin
      vld_d = vld_i;
      if (vld_i) data_d = data_i;
    end
    if (flush) vld_d = 1'b0;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipelined_mult_unit.sv
// Pipelined RV M-extension multiplier (MUL/MULH/MULHSU/MULHU) with tag sideband,
// collapsing-bubble backpressure and a flush that squashes all in-flight ops.
module pipelined_mult_unit
  import mult_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [2:0]        func3,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [TAG_W-1:0]  tag_out,
  output logic              busy
);

  localparam int EXT_W  = DATA_W + 1;
  localparam int PROD_W = 2 * DATA_W + 2;
  localparam int W1     = 2 * EXT_W + 2 + TAG_W;
  localparam int WN     = PROD_W + 2 + TAG_W;

  function automatic logic [DATA_W-1:0] sel_half(input logic [2*DATA_W-1:0] p,
                                                 input logic hi, input logic illegal);
    if (illegal) return '0;
    if (hi)      return p[2*DATA_W-1:DATA_W];
    return p[DATA_W-1:0];
  endfunction

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] adv_p;

  // Stage 1 input: decode mode and extend operands by one bit
  mode_t                    mode_in;
  logic signed [EXT_W-1:0]  a_ext, b_ext;
  logic [W1-1:0]            din_p0, dat_p0;

  assign mode_in = decode_mode(func3);
  assign a_ext   = {mode_in.a_signed & op_a[DATA_W-1], op_a};
  assign b_ext   = {mode_in.b_signed & op_b[DATA_W-1], op_b};
  assign din_p0  = {a_ext, b_ext, mode_in.hi, mode_in.illegal, tag_in};

  // Stage 2 input: signed product of the extended operands
  logic signed [EXT_W-1:0]  a_p0, b_p0;
  logic                     hi_p0, ill_p0;
  logic [TAG_W-1:0]         tag_p0;
  logic signed [PROD_W-1:0] a_w_p0, b_w_p0, prod_p0;
  logic [WN-1:0]            din_p1;
  logic [WN-1:0]            dat_p [1:STAGES-1];

  assign {a_p0, b_p0, hi_p0, ill_p0, tag_p0} = dat_p0;
  assign a_w_p0  = PROD_W'(a_p0);
  assign b_w_p0  = PROD_W'(b_p0);
  assign prod_p0 = a_w_p0 * b_w_p0;
  assign din_p1  = {prod_p0, hi_p0, ill_p0, tag_p0};

  // A stage advances when it or any stage downstream of it is empty, or the consumer takes.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign adv_p[k] = out_ready | ~(&vld_p[STAGES-1:k]);
    if (k == 0) begin : g_first
      pipe_stage_vld #(.W(W1)) u_stage (
        .clk    (clk),
        .arst   (arst),
        .flush  (flush),
        .adv_i  (adv_p[0]),
        .vld_i  (in_valid),
        .data_i (din_p0),
        .vld_o  (vld_p[0]),
        .data_o (dat_p0)
      );
    end else begin : g_rest
      logic [WN-1:0] din;
      if (k == 1) begin : g_prod
        assign din = din_p1;
      end else begin : g_delay
        assign din = dat_p[k-1];
      end
      pipe_stage_vld #(.W(WN)) u_stage (
        .clk    (clk),
        .arst   (arst),
        .flush  (flush),
        .adv_i  (adv_p[k]),
        .vld_i  (vld_p[k-1]),
        .data_i (din),
        .vld_o  (vld_p[k]),
        .data_o (dat_p[k])
      );
    end
  end

  // Output: slice select from the last stage
  logic signed [PROD_W-1:0] prod_pl;
  logic                     hi_pl, ill_pl;
  logic [TAG_W-1:0]         tag_pl;
  logic                     unused_prod_top;

  assign {prod_pl, hi_pl, ill_pl, tag_pl} = dat_p[STAGES-1];
  assign unused_prod_top = ^prod_pl[PROD_W-1:2*DATA_W];

  assign result    = sel_half(prod_pl[2*DATA_W-1:0], hi_pl, ill_pl);
  assign tag_out   = tag_pl;
  assign out_valid = vld_p[STAGES-1];
  assign in_ready  = adv_p[0];
  assign busy      = |vld_p;

endmodule

// File: tb/tb_pipelined_mult_unit.sv
// Scoreboard bench: drivers push expected results on accept, monitors pop and
// compare on every output transfer, for a 64b/2-stage and a 32b/4-stage unit.
module tb_pipelined_mult_unit;
  import mult_pkg::*;

  localparam int S64 = 2;
  localparam int S32 = 4;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  exp_t q64[$];
  exp_t q32[$];
  exp_t m64, m32;

  logic        flush64 = 0, iv64 = 0, or64 = 1;
  logic        ir64, ov64, busy64;
  logic [63:0] a64 = 0, b64 = 0, res64;
  logic [2:0]  f64 = 0;
  logic [4:0]  ti64 = 0, to64;

  logic        flush32 = 0, iv32 = 0, or32 = 1;
  logic        ir32, ov32, busy32;
  logic [31:0] a32 = 0, b32 = 0, res32;
  logic [2:0]  f32 = 0;
  logic [4:0]  ti32 = 0, to32;

  pipelined_mult_unit #(.DATA_W(64), .STAGES(S64), .TAG_W(5)) dut64 (
    .clk(clk), .arst(arst), .flush(flush64), .in_valid(iv64), .in_ready(ir64),
    .op_a(a64), .op_b(b64), .func3(f64), .tag_in(ti64), .out_valid(ov64),
    .out_ready(or64), .result(res64), .tag_out(to64), .busy(busy64)
  );

  pipelined_mult_unit #(.DATA_W(32), .STAGES(S32), .TAG_W(5)) dut32 (
    .clk(clk), .arst(arst), .flush(flush32), .in_valid(iv32), .in_ready(ir32),
    .op_a(a32), .op_b(b32), .func3(f32), .tag_in(ti32), .out_valid(ov32),
    .out_ready(or32), .result(res32), .tag_out(to32), .busy(busy32)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (ov64 && or64) begin
      if (q64.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out64 actual=0x%0h required=none", res64);
      end else begin
        m64 = q64.pop_front();
        chk("result64", res64, m64.res);
        chk("tag64", 64'(to64), 64'(m64.tag));
      end
    end
  end

  always @(negedge clk) begin
    if (ov32 && or32) begin
      if (q32.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out32 actual=0x%0h required=none", res32);
      end else begin
        m32 = q32.pop_front();
        chk("result32", 64'(res32), m32.res);
        chk("tag32", 64'(to32), 64'(m32.tag));
      end
    end
  end

  task automatic send64(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f,
                        input logic [4:0] t, input logic [63:0] req);
    exp_t e;
    bit done = 0;
    int n = 0;
    a64 = a; b64 = b; f64 = f; ti64 = t; iv64 = 1'b1;
    while (!done && n < 100) begin
      @(negedge clk);
      if (ir64 && !flush64) begin
        e.res = req; e.tag = t;
        q64.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    iv64 = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL accept64_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                        input logic [4:0] t, input logic [31:0] req);
    exp_t e;
    bit done = 0;
    int n = 0;
    a32 = a; b32 = b; f32 = f; ti32 = t; iv32 = 1'b1;
    while (!done && n < 100) begin
      @(negedge clk);
      if (ir32 && !flush32) begin
        e.res = 64'(req); e.tag = t;
        q32.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
      n++;
    end
    iv32 = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL accept32_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic drain64();
    int n = 0;
    while (q64.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain64", 64'(q64.size()), 64'd0);
    q64.delete();
  endtask

  task automatic drain32();
    int n = 0;
    while (q32.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain32", 64'(q32.size()), 64'd0);
    q32.delete();
  endtask

  initial begin
    int c0;
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(ov64), 64'd0);
    chk("rst_busy", 64'(busy64), 64'd0);
    chk("rst_result", res64, 64'd0);
    chk("rst_tag", 64'(to64), 64'd0);
    arst = 1'b0;
    chk("rst_in_ready", 64'(ir64), 64'd1);

    // modes and latency
    c0 = cyc;
    send64(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, MUL_F3, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE);
    n = 0;
    while (!ov64 && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency64", 64'(cyc - c0), 64'(S64));
    send64(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, MULH_F3,   5'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    send64(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, MULHSU_F3, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    send64(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, MULHU_F3,  5'd4, 64'h0000_0000_0000_0001);
    send64(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'b100,    5'd5, 64'd0);
    drain64();

    // throughput
    c0 = cyc;
    for (int i = 0; i < 8; i++) send64(64'(i), 64'(i + 1), MUL_F3, 5'(i), 64'(i * (i + 1)));
    chk("throughput64", 64'(cyc - c0), 64'd8);
    drain64();

    // backpressure: full stall
    or64 = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send64(64'(100 + i), 64'd3, MUL_F3, 5'(10 + i), 64'((100 + i) * 3));
      end
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("stall_held", 64'(q64.size()), 64'(S64));
        chk("stall_in_ready", 64'(ir64), 64'd0);
        @(posedge clk); #1;
        or64 = 1'b1;
      end
    join
    drain64();

    // backpressure: lone op, gap, stall -> later op compresses behind it
    send64(64'd7, 64'd6, MUL_F3, 5'd20, 64'd42);
    or64 = 1'b0;
    @(posedge clk); #1;
    fork
      begin
        send64(64'd11, 64'd11, MUL_F3, 5'd21, 64'd121);
        send64(64'd12, 64'd12, MUL_F3, 5'd22, 64'd144);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("compress_held", 64'(q64.size()), 64'd2);
        chk("compress_in_ready", 64'(ir64), 64'd0);
        @(posedge clk); #1;
        or64 = 1'b1;
      end
    join
    drain64();

    // flush: oldest op transfers on the flush edge, rest and new op squashed
    or64 = 1'b0;
    send64(64'd9, 64'd4, MUL_F3, 5'd25, 64'd36);
    send64(64'd8, 64'd4, MUL_F3, 5'd26, 64'd32);
    or64 = 1'b1; flush64 = 1'b1; iv64 = 1'b1;
    a64 = 64'd2; b64 = 64'd2; f64 = MUL_F3; ti64 = 5'd27;
    @(posedge clk); #1;
    flush64 = 1'b0; iv64 = 1'b0;
    q64.delete();
    chk("flush_busy", 64'(busy64), 64'd0);
    chk("flush_out_valid", 64'(ov64), 64'd0);
    send64(64'd3, 64'd5, MUL_F3, 5'd28, 64'd15);
    drain64();

    // asynchronous reset mid-operation
    or64 = 1'b0;
    send64(64'd9, 64'd9, MUL_F3, 5'd29, 64'd81);
    send64(64'd5, 64'd5, MUL_F3, 5'd30, 64'd25);
    #2 arst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(ov64), 64'd0);
    chk("arst_busy", 64'(busy64), 64'd0);
    chk("arst_result", res64, 64'd0);
    arst = 1'b0;
    q64.delete();
    chk("arst_in_ready", 64'(ir64), 64'd1);
    @(posedge clk); #1;
    or64 = 1'b1;

    // 32-bit, 4-stage instance
    c0 = cyc;
    send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, MULHU_F3, 5'd1, 32'hFFFF_FFFE);
    n = 0;
    while (!ov32 && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency32", 64'(cyc - c0), 64'(S32));
    send32(32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_F3,  5'd2, 32'h0000_0001);
    send32(32'h8000_0000, 32'h8000_0000, MULH_F3, 5'd3, 32'h4000_0000);
    drain32();

    repeat (5) @(posedge clk);
    #1;
    chk("final_q64", 64'(q64.size()), 64'd0);
    chk("final_busy64", 64'(busy64), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
